// File: rtl/alu_seq_pkg.sv
// Shared opcodes, flag bit positions and FSM state encoding for alu_seq.
// ALU_SEQ_MUL_EN enables the MUL state.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SBB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_MOV1 = 4'h8;
  localparam logic [3:0] OP_MOV2 = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;
  localparam logic [3:0] OP_SAR  = 4'hC;
  localparam logic [3:0] OP_ROL  = 4'hD;
  localparam logic [3:0] OP_ROR  = 4'hE;
  localparam logic [3:0] OP_MUL  = 4'hF;

  localparam int unsigned FLG_Z  = 4;
  localparam int unsigned FLG_CY = 3;
  localparam int unsigned FLG_S  = 2;
  localparam int unsigned FLG_P  = 1;
  localparam int unsigned FLG_OV = 0;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {StIdle, StShift, StMul} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative engine: one bit of shift/rotate or one multiplier bit per cycle.
// Multiply datapath present only with ALU_SEQ_MUL_EN.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CNTW-1:0]  amount,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [3:0]       op_q;
  logic [WIDTH-1:0] work_q;
  logic [CNTW:0]    cnt_q;
  logic [CNTW:0]    cnt_load;
  logic [WIDTH-1:0] step;
  logic             step_out;

  // For MUL op_q falls to the default arm, so work_q keeps the multiplicand.
  always_comb begin
    step     = work_q;
    step_out = 1'b0;
    case (op_q)
      OP_SHL: begin step = {work_q[WIDTH-2:0], 1'b0};         step_out = work_q[WIDTH-1]; end
      OP_SHR: begin step = {1'b0, work_q[WIDTH-1:1]};         step_out = work_q[0];       end
      OP_SAR: begin step = {work_q[WIDTH-1], work_q[WIDTH-1:1]}; step_out = work_q[0];    end
      OP_ROL: begin step = {work_q[WIDTH-2:0], work_q[WIDTH-1]}; step_out = work_q[WIDTH-1]; end
      OP_ROR: begin step = {work_q[0], work_q[WIDTH-1:1]};    step_out = work_q[0];       end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam logic [CNTW:0] CntMul = (CNTW+1)'(WIDTH);

  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH:0]     acc;
  logic               is_mul;

  assign is_mul   = (op_q == OP_MUL);
  assign cnt_load = (op == OP_MUL) ? CntMul : {1'b0, amount};

  // Shift-add: high half accumulates, product shifts right one bit per cycle.
  always_comb begin
    acc    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, work_q} : '0);
    prod_d = {acc, prod_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
    end else if (start) begin
      prod_q <= {{WIDTH{1'b0}}, b};
    end else if (cnt_q != '0) begin
      prod_q <= prod_d;
    end
  end

  assign result = is_mul ? prod_d[WIDTH-1:0] : step;
  assign carry  = is_mul ? |prod_d[2*WIDTH-1:WIDTH] : step_out;
`else
  logic unused_b;
  assign unused_b = ^b;
  assign cnt_load = {1'b0, amount};
  assign result   = step;
  assign carry    = step_out;
`endif

  assign done = (cnt_q == (CNTW+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      work_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      op_q   <= op;
      work_q <= a;
      cnt_q  <= cnt_load;
    end else if (cnt_q != '0) begin
      cnt_q  <= cnt_q - 1'b1;
      work_q <= step;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes, flag register and iterative ops.
// Define ALU_SEQ_MUL_EN to enable opcode F as an unsigned multiply.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] arg1,
  input  logic [WIDTH-1:0] arg2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [4:0]       flg
);

  state_e           state_q;
  logic [WIDTH-1:0] res_q;
  logic [4:0]       flg_q;
  logic             out_valid_q;

  logic             accept;
  logic             is_shift;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_result;
  logic             iter_carry;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cy;
  logic             alu_ov;
  logic [WIDTH:0]   sum;
  logic             cin;

  function automatic logic [4:0] mk_flg(logic [WIDTH-1:0] r, logic cy, logic ov);
    logic [4:0] f;
    f         = '0;
    f[FLG_Z]  = ~|r;
    f[FLG_CY] = cy;
    f[FLG_S]  = r[WIDTH-1];
    f[FLG_P]  = ^r;
    f[FLG_OV] = ov;
    return f;
  endfunction

  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready) && !rst;
  assign accept   = in_valid && in_ready;
  assign is_shift = (opcode inside {[OP_SHL:OP_ROR]});
  assign cin      = flg_q[FLG_CY];

  always_comb begin
    iter_start = accept && is_shift && (arg2[CNTW-1:0] != '0);
`ifdef ALU_SEQ_MUL_EN
    if (accept && (opcode == OP_MUL)) iter_start = 1'b1;
`endif
  end

  // Single-cycle ops; zero-amount shifts and (without MUL) opcode F pass arg1.
  always_comb begin
    alu_res = arg1;
    alu_cy  = 1'b0;
    alu_ov  = 1'b0;
    sum     = '0;
    case (opcode)
      OP_ADD, OP_ADC: begin
        sum     = {1'b0, arg1} + {1'b0, arg2} + (WIDTH+1)'((opcode == OP_ADC) && cin);
        alu_res = sum[WIDTH-1:0];
        alu_cy  = sum[WIDTH];
        alu_ov  = (arg1[WIDTH-1] == arg2[WIDTH-1]) && (alu_res[WIDTH-1] != arg1[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        sum     = {1'b0, arg1} - {1'b0, arg2} - (WIDTH+1)'((opcode == OP_SBB) && cin);
        alu_res = sum[WIDTH-1:0];
        alu_cy  = sum[WIDTH];
        alu_ov  = (arg1[WIDTH-1] != arg2[WIDTH-1]) && (alu_res[WIDTH-1] != arg1[WIDTH-1]);
      end
      OP_AND:  alu_res = arg1 & arg2;
      OP_OR:   alu_res = arg1 | arg2;
      OP_XOR:  alu_res = arg1 ^ arg2;
      OP_NOT:  alu_res = ~arg1;
      OP_MOV2: alu_res = arg2;
      default: ;
    endcase
  end

  alu_seq_iter #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
    .op     (opcode),
    .a      (arg1),
    .b      (arg2),
    .amount (arg2[CNTW-1:0]),
    .done   (iter_done),
    .result (iter_result),
    .carry  (iter_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      res_q       <= '0;
      flg_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (iter_start) begin
`ifdef ALU_SEQ_MUL_EN
            state_q <= (opcode == OP_MUL) ? StMul : StShift;
`else
            state_q <= StShift;
`endif
          end else if (accept) begin
            res_q       <= alu_res;
            flg_q       <= mk_flg(alu_res, alu_cy, alu_ov);
            out_valid_q <= 1'b1;
          end
        end
        StShift: begin
          if (iter_done) begin
            res_q       <= iter_result;
            flg_q       <= mk_flg(iter_result, iter_carry, 1'b0);
            out_valid_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        StMul: begin
          if (iter_done) begin
            res_q       <= iter_result;
            flg_q       <= mk_flg(iter_result, iter_carry, iter_carry);
            out_valid_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign res       = res_q;
  assign flg       = flg_q;
  assign out_valid = out_valid_q;

endmodule
